mem_port_arbiter: RTL and testbench

//   Shares one memory port between the instruction-fetch (IF) and data-memory
//   (DM) stages of the CPU. One transaction outstanding at a time. Fixed DM

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and DM, one access in flight; DM priority with IF anti-starvation.
// Grant and mem_req_o appear the cycle after arbitration; rvalid the cycle after ack or timeout abort.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              busy_o
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [31:0]       ABORT_WORD = 32'hDEADBEEF;
  localparam logic [DATA_W-1:0] ABORT_DATA = {(DATA_W/32){ABORT_WORD}};
  localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0]        WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic       owner_if_q;
  logic [3:0] starve_q, starve_d;
  logic [7:0] wait_q;
  logic       arb_go;
  logic       if_wins;

  always_comb begin
    arb_go   = (state_q == IDLE) && start_i && (if_req_i || dm_req_i);
    if_wins  = if_req_i && (!dm_req_i || (starve_q == STARVE_LIM));
    starve_d = starve_q;
    if (if_wins) begin
      starve_d = '0;
    end else if (if_req_i && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  assign busy_o = (state_q == WAIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      owner_if_q  <= 1'b0;
      starve_q    <= '0;
      wait_q      <= '0;
      if_gnt_o    <= 1'b0;
      dm_gnt_o    <= 1'b0;
      if_rvalid_o <= 1'b0;
      dm_rvalid_o <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      if_gnt_o    <= 1'b0;
      dm_gnt_o    <= 1'b0;
      if_rvalid_o <= 1'b0;
      dm_rvalid_o <= 1'b0;
      err_o       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_go) begin
            state_q     <= WAIT;
            owner_if_q  <= if_wins;
            starve_q    <= starve_d;
            wait_q      <= '0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= if_wins ? 1'b0 : dm_we_i;
            mem_addr_o  <= if_wins ? if_addr_i : dm_addr_i;
            mem_wdata_o <= if_wins ? '0 : dm_wdata_i;
            if_gnt_o    <= if_wins;
            dm_gnt_o    <= !if_wins;
          end
        end
        WAIT: begin
          // Ack beats a timeout landing on the same edge.
          if (mem_ack_i) begin
            state_q     <= IDLE;
            mem_req_o   <= 1'b0;
            if (!mem_we_o) rdata_o <= mem_rdata_i;
            if_rvalid_o <= owner_if_q;
            dm_rvalid_o <= !owner_if_q;
          end else if (wait_q == WAIT_LAST) begin
            state_q     <= IDLE;
            mem_req_o   <= 1'b0;
            rdata_o     <= ABORT_DATA;
            err_o       <= 1'b1;
            if_rvalid_o <= owner_if_q;
            dm_rvalid_o <= !owner_if_q;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, reads, writes, priority/starvation, timeout, start gate.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_gnt_o;
  logic        dm_rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(3), .TIMEOUT(15)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .busy_o(busy_o)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Both requesters held high with an immediate ack; expected order repeats DM,DM,DM,IF.
  task automatic grant_seq(input int n);
    logic exp_if;
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h40;
    mem_ack_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp_if      = ((k % 4) == 3);
      mem_rdata_i = 32'h1000 + k;
      tick();
      chk("order_gnt", {30'd0, if_gnt_o, dm_gnt_o}, {30'd0, exp_if, !exp_if});
      chk("order_addr", mem_addr_o, exp_if ? 32'h100 : 32'h40);
      if (k == n - 1) begin
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
      end
      tick();
      chk("order_rvalid", {30'd0, if_rvalid_o, dm_rvalid_o}, {30'd0, exp_if, !exp_if});
      chk("order_rdata", rdata_o, 32'h1000 + k);
    end
    mem_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_rdata_i = '0; mem_ack_i = 1'b0;
    #1;
    chk("rst_outputs", {27'd0, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, mem_req_o}, 32'd0);
    chk("rst_misc", {29'd0, err_o, mem_we_o, busy_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    tick(); tick();
    rst_i = 1'b1;
    tick();

    // DM read, ack in first WAIT cycle, then back-to-back access.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1234;
    tick();
    chk("rd_gnt", {30'd0, if_gnt_o, dm_gnt_o}, 32'b01);
    chk("rd_memreq", {30'd0, mem_req_o, busy_o}, 32'b11);
    chk("rd_addr", mem_addr_o, 32'h40);
    chk("rd_we", {31'd0, mem_we_o}, 32'd0);
    dm_req_i = 1'b0;
    tick();
    chk("rd_rvalid", {29'd0, err_o, if_rvalid_o, dm_rvalid_o}, 32'b001);
    chk("rd_rdata", rdata_o, 32'h1234);
    chk("rd_gnt_pulse", {30'd0, dm_gnt_o, mem_req_o}, 32'd0);
    dm_req_i = 1'b1; dm_addr_i = 32'h44; mem_rdata_i = 32'h5678;
    tick();
    chk("thru_gnt", {31'd0, dm_gnt_o}, 32'd1);
    chk("thru_addr", mem_addr_o, 32'h44);
    dm_req_i = 1'b0;
    tick();
    chk("thru_rdata", rdata_o, 32'h5678);
    chk("thru_rvalid", {31'd0, dm_rvalid_o}, 32'd1);

    // DM write: read data bus ignored, rdata_o keeps the last read.
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h80; dm_wdata_i = 32'hCAFE;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h9999;
    tick();
    chk("wr_gnt", {31'd0, dm_gnt_o}, 32'd1);
    chk("wr_we", {31'd0, mem_we_o}, 32'd1);
    chk("wr_wdata", mem_wdata_o, 32'hCAFE);
    chk("wr_addr", mem_addr_o, 32'h80);
    dm_req_i = 1'b0; dm_we_i = 1'b0; mem_ack_i = 1'b1;
    tick();
    chk("wr_rvalid", {30'd0, err_o, dm_rvalid_o}, 32'b01);
    chk("wr_rdata_keep", rdata_o, 32'h5678);
    mem_ack_i = 1'b0;

    grant_seq(8);

    // Build starvation count to 2, reset mid-WAIT, confirm count cleared.
    if_req_i = 1'b1; dm_req_i = 1'b1; mem_ack_i = 1'b1;
    tick(); tick(); tick(); tick();
    if_req_i = 1'b0; mem_ack_i = 1'b0;
    tick();
    chk("rst_pre_gnt", {31'd0, dm_gnt_o}, 32'd1);
    dm_req_i = 1'b0;
    tick();
    chk("rst_pre_req", {31'd0, mem_req_o}, 32'd1);
    #1 rst_i = 1'b0;
    #1;
    chk("rst_async_req", {30'd0, mem_req_o, busy_o}, 32'd0);
    mem_ack_i = 1'b1;
    tick();
    #1 rst_i = 1'b1;
    tick();
    chk("rst_no_rvalid", {28'd0, if_rvalid_o, dm_rvalid_o, err_o, mem_req_o}, 32'd0);
    mem_ack_i = 1'b0;
    grant_seq(4);

    // Timeout abort on the 15th WAIT cycle without ack.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    tick();
    chk("to_gnt", {31'd0, dm_gnt_o}, 32'd1);
    dm_req_i = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("to_still_wait", {29'd0, mem_req_o, dm_rvalid_o, err_o}, 32'b100);
    tick();
    chk("to_err", {28'd0, mem_req_o, err_o, if_rvalid_o, dm_rvalid_o}, 32'b0101);
    chk("to_rdata", rdata_o, 32'hDEADBEEF);
    tick();
    chk("to_err_pulse", {31'd0, err_o}, 32'd0);

    // Ack arriving on the 15th WAIT cycle completes normally.
    if_req_i = 1'b1; if_addr_i = 32'h300;
    tick();
    chk("ack15_gnt", {30'd0, if_gnt_o, dm_gnt_o}, 32'b10);
    if_req_i = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hABCD;
    tick();
    chk("ack15_done", {29'd0, err_o, if_rvalid_o, dm_rvalid_o}, 32'b010);
    chk("ack15_rdata", rdata_o, 32'hABCD);

    // Start gate holds off IF for 10 cycles.
    start_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h500; mem_rdata_i = 32'h77;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gate_hold", {30'd0, if_gnt_o, mem_req_o}, 32'd0);
    end
    start_i = 1'b1;
    tick();
    chk("gate_gnt", {30'd0, if_gnt_o, dm_gnt_o}, 32'b10);
    chk("gate_addr", mem_addr_o, 32'h500);
    if_req_i = 1'b0;
    tick();
    chk("gate_rvalid", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'b10);
    chk("gate_rdata", rdata_o, 32'h77);
    mem_ack_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
